// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and idle level for the C serial interface
package seq_pkg;

  // Gray encoded so SHIFT<->DONE and IDLE<->SHIFT differ by one bit; 2'b10 is unused.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b11
  } seq_state_t;

  localparam logic SEQ_IDLE_LVL = 1'b0;

endpackage

// File: rtl/seq_bit_ctr.sv
// rtl/seq_bit_ctr.sv - bit index and repeat down-counters with wrap/final flags
module seq_bit_ctr #(
  parameter int LEN_W = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic             clr,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_rep,
  output logic [LEN_W-1:0] idx,
  output logic [REP_W-1:0] rep,
  output logic [LEN_W-1:0] len,
  output logic             wrap,
  output logic             fin
);

  assign wrap = (idx == '0) && (rep != '0);
  assign fin  = (idx == '0) && (rep == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      rep <= '0;
      len <= '0;
    end else if (clr) begin
      idx <= '0;
      rep <= '0;
      len <= '0;
    end else if (load) begin
      len <= load_len;
      rep <= load_rep;
      idx <= (load_len == '0) ? '0 : load_len - LEN_W'(1);
    end else if (dec) begin
      // Reload on bit 0 with repeats left, so repetitions run back-to-back.
      if (idx == '0) begin
        if (rep != '0) begin
          rep <= rep - REP_W'(1);
          idx <= len - LEN_W'(1);
        end
      end else begin
        idx <= idx - LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial pattern transmitter driving the C stream MSB-first
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int   PAT_W    = 8,
  parameter int   LEN_W    = 4,
  parameter int   REP_W    = 4,
  parameter logic IDLE_LVL = SEQ_IDLE_LVL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] pat_rep,
  input  logic             abort,
  output logic             C,
  output logic             busy,
  output logic             last,
  output logic             done
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  seq_state_t       state, state_nxt;
  logic [PAT_W-1:0] data_q;
  logic [LEN_W-1:0] len_eff, idx, len_q;
  logic [REP_W-1:0] rep;
  logic             wrap, fin, xfer;
  logic             ld, dec, clr, c_nxt, done_nxt, last_nxt;

  function automatic logic bit_at(input logic [PAT_W-1:0] d, input logic [LEN_W-1:0] i);
    bit_at = 1'b0;
    for (int k = 0; k < PAT_W; k++) begin
      if (LEN_W'(k) == i) bit_at = d[k];
    end
  endfunction

  assign len_eff   = (pat_len > PAT_W_L) ? PAT_W_L : pat_len;
  assign pat_ready = (state == ST_IDLE) && !abort;
  assign xfer      = pat_valid && pat_ready;
  assign busy      = (state == ST_SHIFT) || (state == ST_DONE);

  seq_bit_ctr #(.LEN_W(LEN_W), .REP_W(REP_W)) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .dec      (dec),
    .clr      (clr),
    .load_len (len_eff),
    .load_rep (pat_rep),
    .idx      (idx),
    .rep      (rep),
    .len      (len_q),
    .wrap     (wrap),
    .fin      (fin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    c_nxt     = IDLE_LVL;
    done_nxt  = 1'b0;
    last_nxt  = 1'b0;
    ld        = 1'b0;
    dec       = 1'b0;
    clr       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          ld = 1'b1;
          if (len_eff != '0) begin
            state_nxt = ST_SHIFT;
            c_nxt     = bit_at(pat_data, len_eff - LEN_W'(1));
            last_nxt  = (len_eff == LEN_W'(1)) && (pat_rep == '0);
          end else begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          clr       = 1'b1;
        end else if (fin) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
          clr       = 1'b1;
        end else begin
          dec = 1'b1;
          // last marks the bit about to appear on C, hence the look-ahead on idx/rep.
          if (wrap) begin
            c_nxt    = bit_at(data_q, len_q - LEN_W'(1));
            last_nxt = (rep == REP_W'(1)) && (len_q == LEN_W'(1));
          end else begin
            c_nxt    = bit_at(data_q, idx - LEN_W'(1));
            last_nxt = (idx == LEN_W'(1)) && (rep == '0);
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      C      <= IDLE_LVL;
      done   <= 1'b0;
      last   <= 1'b0;
    end else begin
      if (xfer) data_q <= pat_data;
      C    <= c_nxt;
      done <= done_nxt;
      last <= last_nxt;
    end
  end

endmodule
